// File: rtl/key_action_decoder.sv
// key_action_decoder: turns six HID keycode slots into two-player Bomberman
// actions (held levels, move pulses with hold-delay auto-repeat, bomb pulses).
// An 8-cycle scan frame snapshots the slots, matches them against the key map
// and commits a new held set unless the frame reports HID rollover.
module key_action_decoder #(
  parameter int unsigned HOLD_DELAY    = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter logic [7:0]  P1_UP    = 8'h1A,
  parameter logic [7:0]  P1_DOWN  = 8'h16,
  parameter logic [7:0]  P1_LEFT  = 8'h04,
  parameter logic [7:0]  P1_RIGHT = 8'h07,
  parameter logic [7:0]  P1_BOMB  = 8'h2C,
  parameter logic [7:0]  P2_UP    = 8'h52,
  parameter logic [7:0]  P2_DOWN  = 8'h51,
  parameter logic [7:0]  P2_LEFT  = 8'h50,
  parameter logic [7:0]  P2_RIGHT = 8'h4F,
  parameter logic [7:0]  P2_BOMB  = 8'h28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  input  logic [7:0] keycode5,
  output logic [4:0] p1_held,
  output logic [4:0] p2_held,
  output logic [3:0] p1_move,
  output logic [3:0] p2_move,
  output logic       p1_bomb,
  output logic       p2_bomb,
  output logic       scan_valid,
  output logic       rollover_err
);

  localparam int unsigned CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_DELAY);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Accumulator / held bit order: [4:0] player 1, [9:5] player 2,
  // each {bomb,right,left,down,up}.
  localparam logic [7:0] CODE_MAP [10] = '{P1_UP, P1_DOWN, P1_LEFT, P1_RIGHT, P1_BOMB,
                                           P2_UP, P2_DOWN, P2_LEFT, P2_RIGHT, P2_BOMB};
  localparam logic [7:0] CODE_NONE     = 8'h00;
  localparam logic [7:0] CODE_ROLLOVER = 8'h01;

  typedef enum logic [2:0] {
    S_CAPTURE, S_SCAN0, S_SCAN1, S_SCAN2, S_SCAN3, S_SCAN4, S_SCAN5, S_COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [9:0]      acc_q, acc_d;
  logic            roll_q, roll_d;
  logic [9:0]      held_q, held_d;
  logic            scan_valid_q, scan_valid_d;
  logic            rollover_err_q, rollover_err_d;

  logic [7:0]      cur_code;
  logic [9:0]      cur_match;

  // Select the shadow slot under scan and match it against the key map.
  always_comb begin
    cur_code = CODE_NONE;
    case (state_q)
      S_SCAN0: cur_code = shadow_q[0];
      S_SCAN1: cur_code = shadow_q[1];
      S_SCAN2: cur_code = shadow_q[2];
      S_SCAN3: cur_code = shadow_q[3];
      S_SCAN4: cur_code = shadow_q[4];
      S_SCAN5: cur_code = shadow_q[5];
      default: cur_code = CODE_NONE;
    endcase
    cur_match = '0;
    for (int k = 0; k < 10; k++) begin
      if (cur_code != CODE_NONE && cur_code == CODE_MAP[k]) cur_match[k] = 1'b1;
    end
  end

  // Scan frame next-state: capture, six match steps, then commit or reject.
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    acc_d          = acc_q;
    roll_d         = roll_q;
    held_d         = held_q;
    scan_valid_d   = 1'b0;
    rollover_err_d = rollover_err_q;
    case (state_q)
      S_CAPTURE: begin
        shadow_d = {keycode5, keycode4, keycode3, keycode2, keycode1, keycode0};
        acc_d    = '0;
        roll_d   = 1'b0;
        state_d  = S_SCAN0;
      end
      S_SCAN0: state_d = S_SCAN1;
      S_SCAN1: state_d = S_SCAN2;
      S_SCAN2: state_d = S_SCAN3;
      S_SCAN3: state_d = S_SCAN4;
      S_SCAN4: state_d = S_SCAN5;
      S_SCAN5: state_d = S_COMMIT;
      S_COMMIT: begin
        if (!roll_q) begin
          held_d         = acc_q;
          scan_valid_d   = 1'b1;
          rollover_err_d = 1'b0;
        end else begin
          rollover_err_d = 1'b1;
        end
        state_d = S_CAPTURE;
      end
      default: state_d = S_CAPTURE;
    endcase
    if (state_q != S_CAPTURE && state_q != S_COMMIT) begin
      acc_d = acc_q | cur_match;
      if (cur_code == CODE_ROLLOVER) roll_d = 1'b1;
    end
  end

  // Scan FSM registers with its registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_CAPTURE;
      shadow_q       <= '0;
      acc_q          <= '0;
      roll_q         <= 1'b0;
      held_q         <= '0;
      scan_valid_q   <= 1'b0;
      rollover_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      acc_q          <= acc_d;
      roll_q         <= roll_d;
      held_q         <= held_d;
      scan_valid_q   <= scan_valid_d;
      rollover_err_q <= rollover_err_d;
    end
  end

  // Opposite directions cancel; channels [3:0] player 1, [7:4] player 2.
  logic [7:0] move_eff;
  logic [1:0] bomb_eff;
  logic [7:0] move_pulse;
  logic [1:0] bomb_pulse;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      assign move_eff[gi*4 + 0] = held_q[gi*5 + 0] & ~held_q[gi*5 + 1];
      assign move_eff[gi*4 + 1] = held_q[gi*5 + 1] & ~held_q[gi*5 + 0];
      assign move_eff[gi*4 + 2] = held_q[gi*5 + 2] & ~held_q[gi*5 + 3];
      assign move_eff[gi*4 + 3] = held_q[gi*5 + 3] & ~held_q[gi*5 + 2];
      assign bomb_eff[gi]       = held_q[gi*5 + 4];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_move
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             prev_q, pulse_q, pulse_d;

      // Press pulse on rising edge, then hold-delay and periodic repeats.
      always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (move_eff[gi] && !prev_q) begin
          pulse_d = 1'b1;
          cnt_d   = HOLD_LOAD;
        end else if (move_eff[gi] && cnt_q == CNT_ONE) begin
          pulse_d = 1'b1;
          cnt_d   = REPEAT_LOAD;
        end else if (move_eff[gi]) begin
          cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
        end else begin
          cnt_d = '0;
        end
      end

      // Move channel state.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          cnt_q   <= '0;
          prev_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          prev_q  <= move_eff[gi];
          pulse_q <= pulse_d;
        end
      end

      assign move_pulse[gi] = pulse_q;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bomb
      logic prev_q, pulse_q;

      // Bomb fires once per press, never repeats.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          prev_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          prev_q  <= bomb_eff[gi];
          pulse_q <= bomb_eff[gi] & ~prev_q;
        end
      end

      assign bomb_pulse[gi] = pulse_q;
    end
  endgenerate

  assign p1_held      = held_q[4:0];
  assign p2_held      = held_q[9:5];
  assign p1_move      = move_pulse[3:0];
  assign p2_move      = move_pulse[7:4];
  assign p1_bomb      = bomb_pulse[0];
  assign p2_bomb      = bomb_pulse[1];
  assign scan_valid   = scan_valid_q;
  assign rollover_err = rollover_err_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Bench for key_action_decoder: directed scenarios plus random keycode churn,
// checked every cycle against a frame-level reference model.
module tb_key_action_decoder;

  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam logic [7:0] CODES [10] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C,
                                        8'h52, 8'h51, 8'h50, 8'h4F, 8'h28};

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] kc [6];
  logic [4:0] p1_held, p2_held;
  logic [3:0] p1_move, p2_move;
  logic       p1_bomb, p2_bomb, scan_valid, rollover_err;

  key_action_decoder #(.HOLD_DELAY(HOLD), .REPEAT_PERIOD(REP)) dut (
    .Clk(Clk), .Reset(Reset),
    .keycode0(kc[0]), .keycode1(kc[1]), .keycode2(kc[2]),
    .keycode3(kc[3]), .keycode4(kc[4]), .keycode5(kc[5]),
    .p1_held(p1_held), .p2_held(p2_held), .p1_move(p1_move), .p2_move(p2_move),
    .p1_bomb(p1_bomb), .p2_bomb(p2_bomb), .scan_valid(scan_valid),
    .rollover_err(rollover_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: edges since reset release, frame snapshot,
  // committed held set, and how long each effective channel has been on.
  int         k;
  logic [7:0] snap [6];
  logic [9:0] m_held;
  int         mlen [8];
  int         blen [2];
  logic       m_sv, m_roll;
  logic [7:0] m_mv;
  logic [1:0] m_bomb;

  // Observation statistics for the directed scenarios.
  int q_up [$];
  int n_b1, n_b2, b1_cyc, b2_cyc, n_p2mv, n_p2up, n_p1rt, n_p1dn, n_sv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Pulse due after 'len' consecutive on-cycles: press, then +HOLD, then every REP.
  function automatic bit pulse_due(input int len, input bit repeats);
    int d;
    if (len == 0) return 1'b0;
    d = len - 1;
    if (d == 0) return 1'b1;
    if (!repeats) return 1'b0;
    return (d >= HOLD) && ((d - HOLD) % REP == 0);
  endfunction

  task automatic model_reset();
    k = 0;
    m_held = '0;
    for (int i = 0; i < 8; i++) mlen[i] = 0;
    for (int i = 0; i < 2; i++) blen[i] = 0;
    for (int i = 0; i < 6; i++) snap[i] = 8'h00;
    m_sv = 1'b0;
    m_roll = 1'b0;
    m_mv = '0;
    m_bomb = '0;
  endtask

  task automatic clear_stats();
    q_up.delete();
    n_b1 = 0; n_b2 = 0; b1_cyc = -1; b2_cyc = -2;
    n_p2mv = 0; n_p2up = 0; n_p1rt = 0; n_p1dn = 0; n_sv = 0;
  endtask

  // One clock: advance the model across the edge, then compare every output.
  task automatic step();
    logic [7:0] e;
    logic [1:0] be;
    logic [4:0] h;
    logic       roll;
    logic [9:0] dec;
    @(posedge Clk);
    #1;
    cyc++;
    if (Reset) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        h = m_held[p*5 +: 5];
        e[p*4 + 0] = h[0] & ~h[1];
        e[p*4 + 1] = h[1] & ~h[0];
        e[p*4 + 2] = h[2] & ~h[3];
        e[p*4 + 3] = h[3] & ~h[2];
        be[p]      = h[4];
      end
      for (int i = 0; i < 8; i++) begin
        mlen[i] = e[i] ? mlen[i] + 1 : 0;
        m_mv[i] = pulse_due(mlen[i], 1'b1);
      end
      for (int i = 0; i < 2; i++) begin
        blen[i] = be[i] ? blen[i] + 1 : 0;
        m_bomb[i] = pulse_due(blen[i], 1'b0);
      end
      m_sv = 1'b0;
      if (k % 8 == 0) for (int i = 0; i < 6; i++) snap[i] = kc[i];
      if (k % 8 == 7) begin
        roll = 1'b0;
        dec = '0;
        for (int s = 0; s < 6; s++) begin
          if (snap[s] == 8'h01) roll = 1'b1;
          for (int b = 0; b < 10; b++) if (snap[s] == CODES[b]) dec[b] = 1'b1;
        end
        if (roll) m_roll = 1'b1;
        else begin
          m_held = dec;
          m_sv = 1'b1;
          m_roll = 1'b0;
        end
      end
      k++;
    end
    check("held", 32'({p2_held, p1_held}), 32'(m_held));
    check("move", 32'({p2_move, p1_move}), 32'(m_mv));
    check("bomb", 32'({p2_bomb, p1_bomb}), 32'(m_bomb));
    check("status", 32'({scan_valid, rollover_err}), 32'({m_sv, m_roll}));
    if (p1_move[0]) q_up.push_back(cyc);
    if (p1_bomb) begin n_b1++; b1_cyc = cyc; end
    if (p2_bomb) begin n_b2++; b2_cyc = cyc; end
    if (p2_move != 4'd0) n_p2mv++;
    if (p2_move[0]) n_p2up++;
    if (p1_move[3]) n_p1rt++;
    if (p1_move[1]) n_p1dn++;
    if (scan_valid) n_sv++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 6; i++) kc[i] = 8'h00;
  endtask

  initial begin
    int found;
    int slot;
    int pick;
    logic [7:0] code;

    Reset = 1'b1;
    clear_keys();
    model_reset();
    clear_stats();
    run(3);
    Reset = 1'b0;

    // Reset asserted mid-SCAN3 while W is held.
    kc[0] = 8'h1A;
    while (k % 8 != 4) step();
    Reset = 1'b1;
    #1;
    check("rst_held", 32'({p2_held, p1_held}), 32'd0);
    check("rst_pulses", 32'({p2_move, p1_move, p2_bomb, p1_bomb}), 32'd0);
    check("rst_status", 32'({scan_valid, rollover_err}), 32'd0);
    run(2);
    Reset = 1'b0;
    found = 0;
    for (int i = 0; i < 17 && found == 0; i++) begin
      step();
      if (p1_move[0]) found = 1;
    end
    check("rst_first_pulse_le17", 32'(found), 32'd1);
    clear_keys();
    run(24);

    // W held in slot C: press then repeats at +20, +28, +36.
    clear_stats();
    kc[2] = 8'h1A;
    run(60);
    check("rep_count_ge4", 32'(q_up.size() >= 4), 32'd1);
    if (q_up.size() >= 4) begin
      check("rep_gap_hold", 32'(q_up[1] - q_up[0]), 32'(HOLD));
      check("rep_gap_rep1", 32'(q_up[2] - q_up[1]), 32'(REP));
      check("rep_gap_rep2", 32'(q_up[3] - q_up[2]), 32'(REP));
    end
    kc[2] = 8'h00;
    run(12);
    clear_stats();
    run(40);
    check("rel_no_pulse", 32'(q_up.size()), 32'd0);

    // Both bombs pressed together: one pulse each, same cycle.
    clear_stats();
    kc[0] = 8'h2C;
    kc[5] = 8'h28;
    run(60);
    check("bomb1_count", 32'(n_b1), 32'd1);
    check("bomb2_count", 32'(n_b2), 32'd1);
    check("bomb_same_cycle", 32'(b1_cyc), 32'(b2_cyc));
    clear_keys();
    run(16);

    // Player 2 up+down together cancel; dropping down yields an up press.
    kc[0] = 8'h52;
    kc[1] = 8'h51;
    run(9);
    clear_stats();
    run(24);
    check("p2_opposed_held", 32'(p2_held), 32'h03);
    check("p2_opposed_moves", 32'(n_p2mv), 32'd0);
    kc[1] = 8'h00;
    clear_stats();
    run(20);
    check("p2_up_press", 32'(n_p2up), 32'd1);
    clear_keys();
    run(16);

    // Rollover frames freeze held; repeats continue on the frozen state.
    kc[0] = 8'h07;
    run(40);
    for (int i = 0; i < 6; i++) kc[i] = 8'h01;
    run(9);
    clear_stats();
    run(24);
    check("roll_err", 32'(rollover_err), 32'd1);
    check("roll_no_valid", 32'(n_sv), 32'd0);
    check("roll_held_frozen", 32'(p1_held), 32'h08);
    check("roll_repeats", 32'(n_p1rt >= 2), 32'd1);
    clear_keys();
    run(16);
    check("roll_cleared", 32'(rollover_err), 32'd0);
    check("roll_held_zero", 32'(p1_held), 32'd0);

    // Same code in every slot acts as a single press.
    for (int i = 0; i < 6; i++) kc[i] = 8'h16;
    clear_stats();
    run(24);
    check("dup_held", 32'(p1_held), 32'h02);
    check("dup_press", 32'(n_p1dn), 32'd1);
    check("dup_scan_valid", 32'(n_sv), 32'd3);
    clear_keys();
    run(16);

    // Random keycode churn with one reset in the middle.
    for (int n = 0; n < 150; n++) begin
      slot = int'($urandom_range(0, 5));
      pick = int'($urandom_range(0, 39));
      if (pick < 20) code = CODES[pick % 10];
      else if (pick < 30) code = 8'h00;
      else if (pick == 30) code = 8'h01;
      else code = 8'($urandom);
      kc[slot] = code;
      if (pick == 31) clear_keys();
      if (n == 75) begin
        Reset = 1'b1;
        run(2);
        Reset = 1'b0;
      end
      run(int'($urandom_range(1, 30)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
